// File: rtl/rsa_mod_encrypt.sv
// RSA public-key encryption engine: ct = (msg ^ e) mod n.
// Right-to-left square-and-multiply over a bit-serial interleaved modular multiplier
// that takes N_W cycles per product and never uses a divider.
// Optional macro RSA_MOD_ENCRYPT_CHK_EN adds an err output that flags n < 2 or msg >= n.
module rsa_mod_encrypt #(
  parameter int unsigned MSG_W = 12,
  parameter int unsigned N_W   = 24,
  parameter int unsigned E_W   = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MSG_W-1:0] msg_in,
  input  logic [E_W-1:0]   e_in,
  input  logic [N_W-1:0]   n_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_W-1:0]   ct_out,
  output logic             busy
`ifdef RSA_MOD_ENCRYPT_CHK_EN
  ,
  output logic             err
`endif
);

  localparam int unsigned     CntW   = (N_W > 1) ? $clog2(N_W) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(N_W - 1);
  // Accumulator holds 2r + a with r, a < n, so two spare bits suffice.
  localparam int unsigned     RW     = N_W + 2;

  typedef enum logic [2:0] {StIdle, StReduce, StCheck, StMul, StSqr, StDone} state_e;

  state_e           state_q, state_d;
  logic [MSG_W-1:0] msg_q, msg_d;
  logic [E_W-1:0]   e_q, e_d;
  logic [N_W-1:0]   n_q, n_d;
  logic [N_W-1:0]   base_q, base_d;
  logic [N_W-1:0]   res_q, res_d;
  logic [RW-1:0]    r_q, r_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [N_W-1:0]   ct_q, ct_d;
`ifdef RSA_MOD_ENCRYPT_CHK_EN
  logic             err_q, err_d;
`endif

  logic [N_W-1:0]  msg_ext;
  logic [CntW-1:0] bit_idx;
  logic [N_W-1:0]  mul_b;
  logic [RW-1:0]   mul_a, n_ext, t0, t1, t2;
  logic            b_bit, mm_last;

  assign msg_ext = N_W'(msg_q);
  assign n_ext   = RW'(n_q);
  assign mm_last = (cnt_q == CntMax);

  // One step of the interleaved modmul: r = 2r + b_i*a, then up to two conditional subtracts.
  always_comb begin
    bit_idx = CntMax - cnt_q;
    mul_a   = RW'(base_q);
    mul_b   = base_q;
    if (state_q == StReduce) begin
      mul_a = RW'(1);
      mul_b = msg_ext;
    end else if (state_q == StMul) begin
      mul_b = res_q;
    end
    b_bit = mul_b[bit_idx];
    t0    = (r_q << 1) + (b_bit ? mul_a : '0);
    t1    = (t0 >= n_ext) ? t0 - n_ext : t0;
    t2    = (t1 >= n_ext) ? t1 - n_ext : t1;
  end

  // Next-state and datapath register updates for the exponentiation sequence.
  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    e_d     = e_q;
    n_d     = n_q;
    base_d  = base_q;
    res_d   = res_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    ct_d    = ct_q;
`ifdef RSA_MOD_ENCRYPT_CHK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          msg_d   = msg_in;
          e_d     = e_in;
          n_d     = n_in;
          res_d   = (n_in == N_W'(1)) ? '0 : N_W'(1);
          r_d     = '0;
          cnt_d   = '0;
          state_d = StReduce;
        end
      end
      StReduce, StMul, StSqr: begin
        r_d   = t2;
        cnt_d = cnt_q + 1'b1;
        if (mm_last) begin
          r_d   = '0;
          cnt_d = '0;
          if (state_q == StMul) begin
            res_d   = t2[N_W-1:0];
            e_d     = e_q >> 1;
            state_d = ((e_q >> 1) == '0) ? StCheck : StSqr;
          end else begin
            base_d  = t2[N_W-1:0];
            state_d = StCheck;
          end
        end
      end
      StCheck: begin
        if (e_q == '0) begin
          // A zero modulus has no meaningful residue; force the result to zero.
          ct_d    = (n_q == '0) ? '0 : res_q;
`ifdef RSA_MOD_ENCRYPT_CHK_EN
          err_d   = (n_q < N_W'(2)) || (msg_ext >= n_q);
`endif
          state_d = StDone;
        end else if (e_q[0]) begin
          state_d = StMul;
        end else begin
          e_d     = e_q >> 1;
          state_d = StSqr;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      msg_q   <= '0;
      e_q     <= '0;
      n_q     <= '0;
      base_q  <= '0;
      res_q   <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      ct_q    <= '0;
`ifdef RSA_MOD_ENCRYPT_CHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      e_q     <= e_d;
      n_q     <= n_d;
      base_q  <= base_d;
      res_q   <= res_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      ct_q    <= ct_d;
`ifdef RSA_MOD_ENCRYPT_CHK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StDone);
  assign ct_out    = ct_q;
`ifdef RSA_MOD_ENCRYPT_CHK_EN
  assign err       = err_q;
`endif

endmodule
